// File: rtl/bus_arbiter2_pkg.sv
// bus_arbiter2_pkg: shared definitions for the two-requester packet arbiter.
//   state_e      - FSM encoding (IDLE=00, G0=01, G1=10; 11 is illegal)
//   REQ0 / REQ1  - requester index constants, also the mux select values
//   other_req()  - the requester that is not the given one
package bus_arbiter2_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StG0   = 2'b01,
    StG1   = 2'b10
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic other_req(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/bus_arbiter2_mux2_w.sv
// mux2_w: pure combinational 2:1 multiplexer for a data word plus its last flag.
// Ports:
//   sel       in   select; REQ0 picks input 0, REQ1 picks input 1
//   in0_data  in   WIDTH data of input 0
//   in0_last  in   last flag of input 0
//   in1_data  in   WIDTH data of input 1
//   in1_last  in   last flag of input 1
//   out_data  out  selected data
//   out_last  out  selected last flag
module mux2_w
  import bus_arbiter2_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  always_comb begin
    out_data = in0_data;
    out_last = in0_last;
    if (sel == REQ1) begin
      out_data = in1_data;
      out_last = in1_last;
    end
  end

endmodule

// File: rtl/bus_arbiter2.sv
// bus_arbiter2: two-requester round-robin packet arbiter driving one downstream bus.
// A grant is held from the first beat of a packet to the beat carrying last, or until
// MAX_BEATS beats have transferred without last (forced release, sticky err_overrun).
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   req0_valid/data/last       requester 0 beat
//   req0_ready                 requester 0 beat accepted this cycle
//   req1_valid/data/last/ready same roles for requester 1
//   out_valid/data/last        granted beat towards the consumer
//   out_ready                  consumer accepts the beat
//   out_src                    index of the current or most recent grant
//   err_overrun                sticky: a packet exceeded MAX_BEATS
module bus_arbiter2
  import bus_arbiter2_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             out_src,
  output logic             err_overrun
);

  localparam logic [8:0] MaxBeats9 = 9'(MAX_BEATS);

  state_e     state_q;
  logic       prio_q;
  logic [7:0] beats_q;
  logic       out_src_q;
  logic       err_q;

  logic       xfer;
  logic [8:0] beats_inc;
  logic       at_max;
  logic       overrun_hit;
  logic       release_grant;

  // out_src_q only changes on grant entry, so it is the live grant index inside G0/G1.
  mux2_w #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel      (out_src_q),
    .in0_data (req0_data),
    .in0_last (req0_last),
    .in1_data (req1_data),
    .in1_last (req1_last),
    .out_data (out_data),
    .out_last (out_last)
  );

  // Zero-cycle ready/valid steering for the granted requester.
  always_comb begin
    out_valid  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      StG0: begin
        out_valid  = req0_valid;
        req0_ready = out_ready;
      end
      StG1: begin
        out_valid  = req1_valid;
        req1_ready = out_ready;
      end
      default: ;
    endcase
  end

  assign xfer          = out_valid & out_ready;
  // 9-bit compare so beats_q = 255 cannot wrap against MAX_BEATS.
  assign beats_inc     = {1'b0, beats_q} + 9'd1;
  assign at_max        = (beats_inc == MaxBeats9);
  assign overrun_hit   = xfer & ~out_last & at_max;
  assign release_grant = xfer & (out_last | at_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      prio_q    <= REQ0;
      beats_q   <= 8'd0;
      out_src_q <= REQ0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req0_valid && (!req1_valid || prio_q == REQ0)) begin
            state_q   <= StG0;
            out_src_q <= REQ0;
            beats_q   <= 8'd0;
          end else if (req1_valid) begin
            state_q   <= StG1;
            out_src_q <= REQ1;
            beats_q   <= 8'd0;
          end
        end
        StG0, StG1: begin
          if (release_grant) begin
            state_q <= StIdle;
            prio_q  <= other_req(out_src_q);
          end else if (xfer) begin
            beats_q <= beats_q + 8'd1;
          end
          if (overrun_hit) begin
            err_q <= 1'b1;
          end
        end
        // Illegal encoding 2'b11 recovers to IDLE.
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_src     = out_src_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_bus_arbiter2.sv
module tb_bus_arbiter2;
  localparam int unsigned W  = 16;
  localparam int unsigned MB = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_last, req0_ready;
  logic [W-1:0] req0_data;
  logic         req1_valid, req1_last, req1_ready;
  logic [W-1:0] req1_data;
  logic         out_valid, out_last, out_ready, out_src, err_overrun;
  logic [W-1:0] out_data;

  int vectors     = 0;
  int miscompares = 0;
  int xfer_cnt    = 0;
  int base;

  bus_arbiter2 #(
    .WIDTH     (W),
    .MAX_BEATS (MB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_last   (req0_last),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_last   (req1_last),
    .req1_ready  (req1_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .out_src     (out_src),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  // Counts downstream transfers to catch lost or duplicated beats.
  always @(posedge clk) begin
    if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_req0_ready", 32'(req0_ready), 32'h0);
    check("rst_req1_ready", 32'(req1_ready), 32'h0);
    check("rst_out_src", 32'(out_src), 32'h0);
    check("rst_err", 32'(err_overrun), 32'h0);
    check("rst_state", 32'(dut.state_q), 32'h0);
    check("rst_prio", 32'(dut.prio_q), 32'h0);
    check("rst_beats", 32'(dut.beats_q), 32'h0);
    reset = 1'b0;

    // Single 3-beat packet from requester 0.
    req0_valid = 1'b1; req0_data = 16'hA1; out_ready = 1'b1;
    #1;
    check("t1_idle_valid", 32'(out_valid), 32'h0);
    check("t1_idle_ready", 32'(req0_ready), 32'h0);
    tick(); #1;
    check("t1_state_g0", 32'(dut.state_q), 32'h1);
    check("t1_beat1", 32'(out_data), 32'hA1);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_ready", 32'(req0_ready), 32'h1);
    check("t1_src", 32'(out_src), 32'h0);
    tick(); req0_data = 16'hA2; #1;
    check("t1_beat2", 32'(out_data), 32'hA2);
    tick(); req0_data = 16'hA3; req0_last = 1'b1; #1;
    check("t1_beat3", 32'(out_data), 32'hA3);
    check("t1_last", 32'(out_last), 32'h1);
    tick(); req0_valid = 1'b0; req0_last = 1'b0; #1;
    check("t1_idle_after", 32'(dut.state_q), 32'h0);
    check("t1_prio", 32'(dut.prio_q), 32'h1);
    check("t1_valid_after", 32'(out_valid), 32'h0);

    // Simultaneous 1-beat packets right after reset: requester 0 wins.
    reset = 1'b1; #1; reset = 1'b0;
    req0_valid = 1'b1; req0_data = 16'h11; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 16'h22; req1_last = 1'b1;
    #1;
    tick(); #1;
    check("t2_first_data", 32'(out_data), 32'h11);
    check("t2_first_src", 32'(out_src), 32'h0);
    check("t2_first_r1rdy", 32'(req1_ready), 32'h0);
    tick(); req0_valid = 1'b0; #1;
    check("t2_gap_valid", 32'(out_valid), 32'h0);
    check("t2_gap_prio", 32'(dut.prio_q), 32'h1);
    check("t2_gap_src", 32'(out_src), 32'h0);
    tick(); #1;
    check("t2_second_data", 32'(out_data), 32'h22);
    check("t2_second_src", 32'(out_src), 32'h1);
    check("t2_second_rdy", 32'(req1_ready), 32'h1);
    tick(); req1_valid = 1'b0; #1;
    check("t2_idle", 32'(dut.state_q), 32'h0);
    check("t2_prio", 32'(dut.prio_q), 32'h0);

    // Back-pressure during a G1 packet.
    base = xfer_cnt;
    req1_valid = 1'b1; req1_data = 16'hB1; req1_last = 1'b0; out_ready = 1'b0;
    #1;
    tick(); #1;
    check("t3_state_g1", 32'(dut.state_q), 32'h2);
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_ready", 32'(req1_ready), 32'h0);
      check("t3_hold_data", 32'(out_data), 32'hB1);
      check("t3_hold_valid", 32'(out_valid), 32'h1);
      check("t3_hold_beats", 32'(dut.beats_q), 32'h0);
      tick(); #1;
    end
    out_ready = 1'b1; #1;
    check("t3_release_ready", 32'(req1_ready), 32'h1);
    check("t3_release_data", 32'(out_data), 32'hB1);
    tick(); req1_data = 16'hB2; req1_last = 1'b1; #1;
    check("t3_beats1", 32'(dut.beats_q), 32'h1);
    check("t3_beat2", 32'(out_data), 32'hB2);
    tick(); req1_valid = 1'b0; req1_last = 1'b0; #1;
    check("t3_xfers", 32'(xfer_cnt - base), 32'h2);
    check("t3_idle", 32'(dut.state_q), 32'h0);
    check("t3_prio", 32'(dut.prio_q), 32'h0);

    // Overrun with MAX_BEATS=4: req0 never sends last, req1 pending.
    req0_valid = 1'b1; req0_data = 16'hC0; req0_last = 1'b0;
    req1_valid = 1'b1; req1_data = 16'hD0; req1_last = 1'b1;
    #1;
    tick(); #1;
    check("t4_state_g0", 32'(dut.state_q), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("t4_data", 32'(out_data), 32'hC0 + 32'(i));
      check("t4_err_pre", 32'(err_overrun), 32'h0);
      tick(); req0_data = 16'(16'hC0 + i + 1); #1;
    end
    check("t4_idle", 32'(dut.state_q), 32'h0);
    check("t4_err", 32'(err_overrun), 32'h1);
    check("t4_prio", 32'(dut.prio_q), 32'h1);
    check("t4_valid_idle", 32'(out_valid), 32'h0);
    tick(); #1;
    check("t4_req1_src", 32'(out_src), 32'h1);
    check("t4_req1_data", 32'(out_data), 32'hD0);
    tick(); req1_valid = 1'b0; #1;
    check("t4_idle2", 32'(dut.state_q), 32'h0);
    check("t4_prio2", 32'(dut.prio_q), 32'h0);
    tick(); #1;
    check("t4_resume_state", 32'(dut.state_q), 32'h1);
    check("t4_resume_data", 32'(out_data), 32'hC4);
    tick(); req0_data = 16'hC5; req0_last = 1'b1; #1;
    check("t4_resume_last", 32'(out_data), 32'hC5);
    tick(); req0_valid = 1'b0; req0_last = 1'b0; #1;
    check("t4_done_idle", 32'(dut.state_q), 32'h0);
    check("t4_err_sticky", 32'(err_overrun), 32'h1);

    // Reset after beat 2 of a 5-beat req1 packet.
    req1_valid = 1'b1; req1_data = 16'hE1; req1_last = 1'b0;
    #1;
    tick(); #1;
    check("t5_state_g1", 32'(dut.state_q), 32'h2);
    tick(); req1_data = 16'hE2; #1;
    tick(); req1_data = 16'hE3; #1;
    check("t5_beats2", 32'(dut.beats_q), 32'h2);
    reset = 1'b1; #1;
    check("t5_rst_valid", 32'(out_valid), 32'h0);
    check("t5_rst_ready", 32'(req1_ready), 32'h0);
    reset = 1'b0; #1;
    check("t5_state", 32'(dut.state_q), 32'h0);
    check("t5_prio", 32'(dut.prio_q), 32'h0);
    check("t5_src", 32'(out_src), 32'h0);
    check("t5_err", 32'(err_overrun), 32'h0);
    req1_valid = 1'b0;

    // Fairness: both continuously offer 1-beat packets.
    req0_valid = 1'b1; req0_data = 16'hF0; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 16'hF1; req1_last = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check("t6_src", 32'(out_src), 32'(k % 2));
      check("t6_data", 32'(out_data), (k % 2 == 0) ? 32'hF0 : 32'hF1);
      check("t6_valid", 32'(out_valid), 32'h1);
      tick(); #1;
      check("t6_gap", 32'(out_valid), 32'h0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter2.md
# bus_arbiter2

Two-requester round-robin packet arbiter that shares one downstream bus between requester 0 and requester 1. It drives the select of a parameterized 2:1 data multiplexer. A grant is held for a whole packet, from the first beat to the beat carrying `last`. It sits in the datapath between two producers and a single consumer, such as a register-file write port or a memory port.

## Interface
- `WIDTH`, default 32: data width of each requester and of the output.
- `MAX_BEATS`, default 16: maximum beats per grant before a forced release; legal range 1..255.
- `clk`, in, 1: single clock; everything except reset is synchronous to the rising edge.
- `reset`, in, 1: asynchronous, active-high; forces the reset state immediately.
- `req0_valid`, in, 1: requester 0 has a beat.
- `req0_data`, in, WIDTH: requester 0 beat data.
- `req0_last`, in, 1: final beat of the requester 0 packet.
- `req0_ready`, out, 1: requester 0 beat accepted this cycle.
- `req1_valid`, `req1_data`, `req1_last`, `req1_ready`: same roles for requester 1.
- `out_valid`, out, 1: output beat valid.
- `out_data`, out, WIDTH: muxed data.
- `out_last`, out, 1: muxed last.
- `out_ready`, in, 1: consumer accepts the beat.
- `out_src`, out, 1: index of the current or most recent grant (mux select).
- `err_overrun`, out, 1: sticky flag; a packet exceeded MAX_BEATS.

## Operation
- States:
  - IDLE: no grant.
  - G0: requester 0 owns the bus.
  - G1: requester 1 owns the bus.
- Priority pointer `prio` (1 bit) names the favoured requester.
- IDLE transitions:
  - Only req0_valid → G0; only req1_valid → G1.
  - Both valid → G[prio].
  - Neither → stay in IDLE.
- In IDLE: out_valid=0, req0_ready=0, req1_ready=0.
- In Gn (combinational pass-through):
  - out_valid = reqn_valid; out_data/out_last = reqn_data/reqn_last.
  - reqn_ready = out_ready; the other ready = 0.
  - out_src = n.
- A transfer is `out_valid && out_ready`.
- Beat counter `beats` (8 bit): cleared on entry to Gn, incremented on each transfer.
- Release (next state IDLE, `prio` ← the other requester) happens on either:
  - a transfer with out_last=1, or
  - a transfer without last where beats+1 == MAX_BEATS; this also sets err_overrun.
- err_overrun clears only on reset.
- reqn_valid dropping while granted: grant is held and out_valid=0; there is no timeout.
- out_src is registered; it holds its value through IDLE and changes only on entry to Gn.
- Reset values: state IDLE, prio=0, beats=0, out_src=0, err_overrun=0. Consequently out_valid=0 and both readies=0.

## Timing
- Arbitration costs one cycle:
  - Request in IDLE at cycle t → grant visible at t+1.
  - The first beat can transfer at t+1 if out_ready=1.
- Within a grant, throughput is 1 beat/cycle, with zero-cycle ready/valid pass-through.
- Between packets there is exactly one IDLE cycle, even when the same or the other requester is waiting.
- The state update in the cycle of a last-beat transfer and the prio update take effect on the same edge.
- Reset asserted mid-packet:
  - state→IDLE asynchronously; out_valid and the readies drop in the same cycle.
  - The partial packet is abandoned; there is no recovery.
- Reset deasserted with both requesters valid: G0 wins (prio=0).
- MAX_BEATS=1: every non-last beat sets err_overrun and releases.

## Structure
- Shared package holds:
  - state encoding: IDLE=2'b00, G0=2'b01, G1=2'b10; 2'b11 is illegal and recovers to IDLE;
  - requester index constants REQ0=1'b0, REQ1=1'b1.
- Sub-module `mux2_w`, parameterized by WIDTH: pure 2:1 mux selected by the grant index. It carries data+last and is instantiated once.
- Top level holds the FSM, prio, beats, out_src, err_overrun and the ready/valid steering.

## Test plan
- Reset then single 3-beat packet: req0 beats 0xA1, 0xA2, 0xA3 (last on the 3rd), out_ready=1 → out_data 0xA1..0xA3 on cycles t+1..t+3; out_src=0; IDLE at t+4; prio=1.
- Simultaneous requests after reset: both valid with 1-beat packets 0x11 (req0) and 0x22 (req1) → 0x11 first; one IDLE cycle; then 0x22; final prio=0.
- Back-pressure: during a G1 packet hold out_ready=0 for 3 cycles → req1_ready=0; out_data stable at the current beat; no beat lost or duplicated; beats does not advance.
- Overrun, MAX_BEATS=4: req0 sends 6 beats, last never asserted → 4 transfers; err_overrun=1 after the 4th; grant releases; remaining beats wait for re-arbitration; req1, if pending, wins next.
- Reset mid-packet: assert reset after beat 2 of a 5-beat req1 packet → out_valid=0 and req1_ready=0 in the same cycle; after deassert state IDLE, prio=0, out_src=0, err_overrun=0.
- Fairness: both requesters continuously send 1-beat packets → grants alternate 0,1,0,1 with one IDLE cycle between each.
